// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU-sharing arbiter: FSM state encoding and
// the grant-index width helper.
package alu_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // Width of a requester index, clog2(NUM_REQ).
  function automatic int unsigned idx_width(input int unsigned num_req);
    return $clog2(num_req);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_priority_pick.sv
// Round-robin pick: rotate requests so the pointer lands at bit 0, take the
// lowest set bit, then rotate the found index back.
module rr_priority_pick
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IW-1:0]        k;
  logic [IW:0]          sum;
  logic                 found;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[NUM_REQ-1:0];
    k     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        k     = IW'(i);
      end
    end
    // ptr < NUM_REQ, so one conditional subtract completes the modulo.
    sum = {1'b0, k} + {1'b0, ptr};
    if (sum >= (IW+1)'(NUM_REQ)) begin
      sum = sum - (IW+1)'(NUM_REQ);
    end
    idx   = sum[IW-1:0];
    valid = found;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one MAC ALU among NUM_REQ requesters: round-robin grant, single
// start pulse, wait for ALU completion, one-cycle DONE back to the winner.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IW = idx_width(NUM_REQ)
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic [NUM_REQ-1:0]         REQ,
  input  logic [NUM_REQ*WIDTH-1:0]   OP_A,
  input  logic [NUM_REQ*WIDTH-1:0]   OP_B,
  output logic [NUM_REQ-1:0]         DONE,
  output logic [WIDTH-1:0]           RESULT,
  output logic                       ALU_START,
  output logic [WIDTH-1:0]           ALU_A,
  output logic [WIDTH-1:0]           ALU_B,
  input  logic                       ALU_DONE,
  input  logic [WIDTH-1:0]           ALU_RESULT,
  output logic [IW-1:0]              GRANT_IDX,
  output logic                       BUSY
);

  arb_state_t state_q, state_d;

  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    grant_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q, result_q;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;

  logic [WIDTH-1:0] op_a_arr [NUM_REQ];
  logic [WIDTH-1:0] op_b_arr [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      op_a_arr[i] = OP_A[i*WIDTH +: WIDTH];
      op_b_arr[i] = OP_B[i*WIDTH +: WIDTH];
    end
  end

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = ISSUE;
      ISSUE:   state_d = ALU_DONE ? RELEASE : WAIT;
      WAIT:    if (ALU_DONE) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant/operand capture, result capture and pointer advance.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      ptr_q    <= '0;
      grant_q  <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_idx;
            alu_a_q <= op_a_arr[pick_idx];
            alu_b_q <= op_b_arr[pick_idx];
          end
        end
        ISSUE, WAIT: begin
          if (ALU_DONE) result_q <= ALU_RESULT;
        end
        RELEASE: begin
          ptr_q <= (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    DONE = '0;
    if (state_q == RELEASE) DONE[grant_q] = 1'b1;
    ALU_START = (state_q == ISSUE);
    BUSY      = (state_q != IDLE);
    ALU_A     = alu_a_q;
    ALU_B     = alu_b_q;
    RESULT    = result_q;
    GRANT_IDX = grant_q;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: table of directed transactions,
// multi-cycle corner sequences, then randomized traffic against a reference.
module tb_alu_share_arbiter;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic         CLK = 1'b0;
  logic         RSTN = 1'b0;
  logic [N-1:0] REQ = '0;
  logic [N*W-1:0] OP_A = '0, OP_B = '0;
  logic [N-1:0] DONE;
  logic [W-1:0] RESULT, ALU_A, ALU_B, ALU_RESULT;
  logic         ALU_START, ALU_DONE, BUSY;
  logic [1:0]   GRANT_IDX;

  // Behavioural ALU: product truncated to W bits, configurable latency.
  logic         zero_lat = 1'b0;
  int unsigned  alu_lat = 1;
  logic         spur = 1'b0;
  logic [W-1:0] spur_val = '0;
  logic         done_r = 1'b0;
  logic [W-1:0] res_r = '0;
  int unsigned  cnt = 0;

  int n_checks = 0;
  int n_fail   = 0;
  int ptr_m    = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    done_r <= 1'b0;
    if (ALU_START && !zero_lat) begin
      res_r <= W'(ALU_A * ALU_B);
      if (alu_lat <= 1) done_r <= 1'b1;
      cnt <= (alu_lat <= 1) ? 0 : alu_lat - 1;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) done_r <= 1'b1;
    end
  end

  assign ALU_DONE   = zero_lat ? ALU_START : (done_r | spur);
  assign ALU_RESULT = zero_lat ? W'(ALU_A * ALU_B) : (spur ? spur_val : res_r);

  alu_share_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .REQ        (REQ),
    .OP_A       (OP_A),
    .OP_B       (OP_B),
    .DONE       (DONE),
    .RESULT     (RESULT),
    .ALU_START  (ALU_START),
    .ALU_A      (ALU_A),
    .ALU_B      (ALU_B),
    .ALU_DONE   (ALU_DONE),
    .ALU_RESULT (ALU_RESULT),
    .GRANT_IDX  (GRANT_IDX),
    .BUSY       (BUSY)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Entered and left at a negedge with the arbiter idle.
  task automatic run_txn(input logic [N-1:0] req, input int unsigned lat, input int exp_w,
                         input logic [N*W-1:0] oa, input logic [N*W-1:0] ob, input string tag);
    logic [W-1:0] a, b;
    int n;
    a = oa[exp_w*W +: W];
    b = ob[exp_w*W +: W];
    zero_lat = (lat == 0);
    alu_lat  = lat;
    check({tag, ".idle_busy"}, BUSY, 0);
    REQ = req; OP_A = oa; OP_B = ob;
    @(negedge CLK);
    check({tag, ".alu_start"}, ALU_START, 1);
    check({tag, ".grant"}, GRANT_IDX, exp_w);
    check({tag, ".alu_a"}, ALU_A, a);
    check({tag, ".alu_b"}, ALU_B, b);
    n = 0;
    while (DONE == '0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check({tag, ".latency"}, n, lat + 1);
    check({tag, ".done"}, DONE, 1 << exp_w);
    check({tag, ".result"}, RESULT, W'(a * b));
    REQ[exp_w] = 1'b0;
    ptr_m = (exp_w + 1) % N;
    @(negedge CLK);
    check({tag, ".done_cleared"}, DONE, 0);
    check({tag, ".result_hold"}, RESULT, W'(a * b));
    REQ = '0;
    zero_lat = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]   req;
    int unsigned    lat;
    int             exp_w;
    logic           fixed_ops;
    logic [N*W-1:0] oa;
    logic [N*W-1:0] ob;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [N-1:0]   r;
    logic [N*W-1:0] oa, ob;
    int             w;
    int unsigned    lat;
    logic           ok;

    vecs[0]  = '{4'b1111, 1, 0, 1'b0, '0, '0};
    vecs[1]  = '{4'b1111, 1, 1, 1'b0, '0, '0};
    vecs[2]  = '{4'b1111, 1, 2, 1'b0, '0, '0};
    vecs[3]  = '{4'b1111, 1, 3, 1'b0, '0, '0};
    vecs[4]  = '{4'b1111, 1, 0, 1'b0, '0, '0};
    vecs[5]  = '{4'b1111, 1, 1, 1'b0, '0, '0};
    vecs[6]  = '{4'b0100, 3, 2, 1'b1, 32'h0012_0000, 32'h0003_0000};
    vecs[7]  = '{4'b1001, 1, 3, 1'b0, '0, '0};
    vecs[8]  = '{4'b1001, 1, 0, 1'b0, '0, '0};
    vecs[9]  = '{4'b1001, 1, 3, 1'b0, '0, '0};
    vecs[10] = '{4'b0010, 0, 1, 1'b0, '0, '0};
    vecs[11] = '{4'b0001, 2, 0, 1'b0, '0, '0};

    repeat (2) @(negedge CLK);
    check("rst.busy", BUSY, 0);
    check("rst.done", DONE, 0);
    check("rst.result", RESULT, 0);
    check("rst.alu_start", ALU_START, 0);
    check("rst.alu_a", ALU_A, 0);
    check("rst.alu_b", ALU_B, 0);
    check("rst.grant", GRANT_IDX, 0);
    RSTN = 1'b1;
    @(negedge CLK);

    // Spurious ALU completion while idle.
    spur = 1'b1; spur_val = 8'hAA;
    @(negedge CLK);
    spur = 1'b0;
    check("spur.done", DONE, 0);
    check("spur.busy", BUSY, 0);
    @(negedge CLK);
    check("spur.done_after", DONE, 0);
    check("spur.result", RESULT, 0);
    check("spur.busy_after", BUSY, 0);

    for (int i = 0; i < 12; i++) begin
      oa = vecs[i].fixed_ops ? vecs[i].oa : {$urandom, $urandom} >> 32;
      ob = vecs[i].fixed_ops ? vecs[i].ob : {$urandom, $urandom} >> 32;
      run_txn(vecs[i].req, vecs[i].lat, vecs[i].exp_w, oa, ob, $sformatf("vec%0d", i));
    end

    // Reset while waiting on the ALU (pointer is 1 here).
    zero_lat = 1'b0; alu_lat = 5;
    REQ = 4'b0100; OP_A = 32'h0055_0000; OP_B = 32'h0002_0000;
    @(negedge CLK);
    check("rstw.alu_start", ALU_START, 1);
    @(negedge CLK);
    check("rstw.busy_wait", BUSY, 1);
    RSTN = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    REQ = '0;
    check("rstw.busy", BUSY, 0);
    check("rstw.alu_a", ALU_A, 0);
    check("rstw.alu_b", ALU_B, 0);
    check("rstw.grant", GRANT_IDX, 0);
    check("rstw.alu_start", ALU_START, 0);
    ptr_m = 0;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (DONE != '0 || BUSY || ALU_START) ok = 1'b0;
    end
    check("rstw.late_alu_done_ignored", ok, 1);
    run_txn(4'b0011, 2, 0, {$urandom}, {$urandom}, "rstw.ptr_cleared");
    run_txn(4'b0010, 1, 1, {$urandom}, {$urandom}, "rstw.fresh");

    // Randomized traffic against the round-robin reference.
    for (int i = 0; i < 40; i++) begin
      r   = N'($urandom_range(1, (1 << N) - 1));
      lat = $urandom_range(0, 4);
      oa  = {$urandom};
      ob  = {$urandom};
      w   = model_pick(r, ptr_m);
      run_txn(r, lat, w, oa, ob, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
